// File: rtl/seq_gen_ser.sv
// Serial pattern generator: latches a WIDTH-bit pattern on start and shifts it out MSB-first,
// replaying it repeat_cnt extra times back-to-back. Optional abort input under SEQ_GEN_ABORT_EN.
module seq_gen_ser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
`ifdef SEQ_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] pat_copy;
    logic [CNT_W-1:0] rep_left;
    logic [IDX_W-1:0] bit_idx;

    // shift_reg holds the not-yet-emitted bits left-aligned; the bit on d_out is already gone from it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            pat_copy  <= '0;
            rep_left  <= '0;
            bit_idx   <= '0;
            d_out     <= 1'b0;
            d_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_SHIFT;
                        pat_copy  <= pattern;
                        shift_reg <= pattern << 1;
                        rep_left  <= repeat_cnt;
                        bit_idx   <= LAST_IDX;
                        d_out     <= pattern[WIDTH-1];
                        d_valid   <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        d_out   <= 1'b0;
                        d_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
`ifdef SEQ_GEN_ABORT_EN
                    if (abort) begin
                        state   <= ST_IDLE;
                        d_out   <= 1'b0;
                        d_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else
`endif
                    if (bit_idx != '0) begin
                        d_out     <= shift_reg[WIDTH-1];
                        shift_reg <= shift_reg << 1;
                        bit_idx   <= bit_idx - IDX_W'(1);
                    end else if (rep_left != '0) begin
                        // Reload from the latched copy so the next pass follows with no bubble.
                        rep_left  <= rep_left - CNT_W'(1);
                        d_out     <= pat_copy[WIDTH-1];
                        shift_reg <= pat_copy << 1;
                        bit_idx   <= LAST_IDX;
                    end else begin
                        state   <= ST_DONE;
                        d_out   <= 1'b0;
                        d_valid <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    d_out   <= 1'b0;
                    d_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    d_out   <= 1'b0;
                    d_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
